// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared SVGA 800x600@60 Hz timing constants and counter widths for the
// horizontal/vertical timing cores, plus a helper that tells whether a
// match constant can be represented in a given comparator width.
package vga_timing_pkg;

    localparam int unsigned HW = 11;   // horizontal counter width
    localparam int unsigned VW = 10;   // vertical counter width

    localparam int unsigned VGA_H_TOTAL      = 1056;
    localparam int unsigned VGA_H_VISIBLE    = 800;
    localparam int unsigned VGA_H_SYNC_START = 840;
    localparam int unsigned VGA_H_SYNC_END   = 968;

    localparam int unsigned VGA_V_VISIBLE    = 600;
    localparam int unsigned VGA_V_SYNC_START = 601;
    localparam int unsigned VGA_V_SYNC_END   = 605;
    localparam int unsigned VGA_V_TOTAL      = 628;

    // True when value fits in an unsigned field of the given width. A constant
    // that does not fit must never match; truncating it would alias it onto a
    // real count value.
    function automatic bit fits_width(input int unsigned value, input int unsigned width);
        return (width >= 32) || (value < (32'd1 << width));
    endfunction

endpackage

// File: rtl/vga_h_timing_core_eq_comparator.sv
// eq_comparator
// Purely combinational equality strobe.
// Ports:
//   input_value  [WIDTH-1:0]  live count being watched
//   loaded_value [WIDTH-1:0]  constant to match against
//   match                     high while input_value == loaded_value
module eq_comparator #(
    parameter int unsigned WIDTH = 11
) (
    input  logic [WIDTH-1:0] input_value,
    input  logic [WIDTH-1:0] loaded_value,
    output logic             match
);

    assign match = (input_value == loaded_value);

endmodule

// File: rtl/vga_h_timing_core.sv
// vga_h_timing_core
// Horizontal timing core for the 800x600@60 Hz pipeline (40 MHz pixel clock).
// Free-running horizontal pixel counter, a registered once-per-line pulse for
// the vertical counter, and equality strobes on hcount and on the external
// vcount for the downstream window SR flops.
// Ports:
//   clk                 pixel clock, rising edge
//   rst                 asynchronous active-low reset
//   vcount      [9:0]   current line from the vertical counter
//   hcount      [10:0]  current pixel index, 0..H_TOTAL-1
//   line_end            registered pulse, high while hcount == H_TOTAL-1
//   h_match_*           hcount equality strobes (last/visible/sync start/end)
//   v_match_*           vcount equality strobes (visible/sync start/end/total)
module vga_h_timing_core
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL      = VGA_H_TOTAL,
    parameter int unsigned H_VISIBLE    = VGA_H_VISIBLE,
    parameter int unsigned H_SYNC_START = VGA_H_SYNC_START,
    parameter int unsigned H_SYNC_END   = VGA_H_SYNC_END,
    parameter int unsigned V_VISIBLE    = VGA_V_VISIBLE,
    parameter int unsigned V_SYNC_START = VGA_V_SYNC_START,
    parameter int unsigned V_SYNC_END   = VGA_V_SYNC_END,
    parameter int unsigned V_TOTAL      = VGA_V_TOTAL
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    vcount,
    output logic [10:0]   hcount,
    output logic          line_end,
    output logic          h_match_last,
    output logic          h_match_visible,
    output logic          h_match_sync_start,
    output logic          h_match_sync_end,
    output logic          v_match_visible,
    output logic          v_match_sync_start,
    output logic          v_match_sync_end,
    output logic          v_match_total
);

    localparam int unsigned H_LAST = H_TOTAL - 1;

    // Representability of each constant; unrepresentable ones gate their
    // strobe off permanently instead of matching a truncated value.
    localparam bit H_LAST_OK  = fits_width(H_LAST, HW);
    localparam bit H_VIS_OK   = fits_width(H_VISIBLE, HW);
    localparam bit H_SS_OK    = fits_width(H_SYNC_START, HW);
    localparam bit H_SE_OK    = fits_width(H_SYNC_END, HW);
    localparam bit V_VIS_OK   = fits_width(V_VISIBLE, VW);
    localparam bit V_SS_OK    = fits_width(V_SYNC_START, VW);
    localparam bit V_SE_OK    = fits_width(V_SYNC_END, VW);
    localparam bit V_TOT_OK   = fits_width(V_TOTAL, VW);

    localparam logic [HW-1:0] H_LAST_VAL = H_LAST[HW-1:0];
    localparam logic [HW-1:0] H_VIS_VAL  = H_VISIBLE[HW-1:0];
    localparam logic [HW-1:0] H_SS_VAL   = H_SYNC_START[HW-1:0];
    localparam logic [HW-1:0] H_SE_VAL   = H_SYNC_END[HW-1:0];
    localparam logic [VW-1:0] V_VIS_VAL  = V_VISIBLE[VW-1:0];
    localparam logic [VW-1:0] V_SS_VAL   = V_SYNC_START[VW-1:0];
    localparam logic [VW-1:0] V_SE_VAL   = V_SYNC_END[VW-1:0];
    localparam logic [VW-1:0] V_TOT_VAL  = V_TOTAL[VW-1:0];

    logic          h_last_eq;
    logic          h_vis_eq;
    logic          h_ss_eq;
    logic          h_se_eq;
    logic          v_vis_eq;
    logic          v_ss_eq;
    logic          v_se_eq;
    logic          v_tot_eq;
    logic [HW-1:0] hcount_next;

    eq_comparator #(.WIDTH(HW)) u_h_last (.input_value(hcount), .loaded_value(H_LAST_VAL), .match(h_last_eq));
    eq_comparator #(.WIDTH(HW)) u_h_vis  (.input_value(hcount), .loaded_value(H_VIS_VAL),  .match(h_vis_eq));
    eq_comparator #(.WIDTH(HW)) u_h_ss   (.input_value(hcount), .loaded_value(H_SS_VAL),   .match(h_ss_eq));
    eq_comparator #(.WIDTH(HW)) u_h_se   (.input_value(hcount), .loaded_value(H_SE_VAL),   .match(h_se_eq));
    eq_comparator #(.WIDTH(VW)) u_v_vis  (.input_value(vcount), .loaded_value(V_VIS_VAL),  .match(v_vis_eq));
    eq_comparator #(.WIDTH(VW)) u_v_ss   (.input_value(vcount), .loaded_value(V_SS_VAL),   .match(v_ss_eq));
    eq_comparator #(.WIDTH(VW)) u_v_se   (.input_value(vcount), .loaded_value(V_SE_VAL),   .match(v_se_eq));
    eq_comparator #(.WIDTH(VW)) u_v_tot  (.input_value(vcount), .loaded_value(V_TOT_VAL),  .match(v_tot_eq));

    assign h_match_last       = H_LAST_OK && h_last_eq;
    assign h_match_visible    = H_VIS_OK  && h_vis_eq;
    assign h_match_sync_start = H_SS_OK   && h_ss_eq;
    assign h_match_sync_end   = H_SE_OK   && h_se_eq;
    assign v_match_visible    = V_VIS_OK  && v_vis_eq;
    assign v_match_sync_start = V_SS_OK   && v_ss_eq;
    assign v_match_sync_end   = V_SE_OK   && v_se_eq;
    assign v_match_total      = V_TOT_OK  && v_tot_eq;

    always_comb begin
        hcount_next = h_last_eq ? '0 : hcount + 1'b1;
    end

    // line_end is registered from the next-count decode so it is high in the
    // same cycle as hcount == H_TOTAL-1 yet comes straight off a flop; it is
    // used as a clock by the vertical counter and must not glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount   <= '0;
            line_end <= 1'b0;
        end else begin
            hcount   <= hcount_next;
            line_end <= (hcount_next == H_LAST_VAL);
        end
    end

endmodule

// File: tb/tb_vga_h_timing_core.sv
`timescale 1ns/1ps
module tb_vga_h_timing_core;

    logic        clk;
    logic        rst;
    logic [9:0]  vcount;

    logic [10:0] hcount;
    logic        line_end, h_match_last, h_match_visible, h_match_sync_start, h_match_sync_end;
    logic        v_match_visible, v_match_sync_start, v_match_sync_end, v_match_total;

    // Second instance with an unrepresentable H_VISIBLE
    logic [10:0] hcount_b;
    logic        line_end_b, h_last_b, h_vis_b, h_ss_b, h_se_b;
    logic        v_vis_b, v_ss_b, v_se_b, v_tot_b;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #12.5 clk = ~clk;   // 40 MHz

    vga_h_timing_core dut (
        .clk(clk), .rst(rst), .vcount(vcount), .hcount(hcount), .line_end(line_end),
        .h_match_last(h_match_last), .h_match_visible(h_match_visible),
        .h_match_sync_start(h_match_sync_start), .h_match_sync_end(h_match_sync_end),
        .v_match_visible(v_match_visible), .v_match_sync_start(v_match_sync_start),
        .v_match_sync_end(v_match_sync_end), .v_match_total(v_match_total)
    );

    vga_h_timing_core #(.H_VISIBLE(2048)) dut_b (
        .clk(clk), .rst(rst), .vcount(vcount), .hcount(hcount_b), .line_end(line_end_b),
        .h_match_last(h_last_b), .h_match_visible(h_vis_b),
        .h_match_sync_start(h_ss_b), .h_match_sync_end(h_se_b),
        .v_match_visible(v_vis_b), .v_match_sync_start(v_ss_b),
        .v_match_sync_end(v_se_b), .v_match_total(v_tot_b)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // {line_end, h_match_last, h_match_visible, h_match_sync_start, h_match_sync_end}
    function automatic logic [4:0] h_model(input int h);
        return {h == 1055, h == 1055, h == 800, h == 840, h == 968};
    endfunction

    function automatic logic [4:0] h_actual();
        return {line_end, h_match_last, h_match_visible, h_match_sync_start, h_match_sync_end};
    endfunction

    // ---------------- vertical vector table ----------------
    typedef struct {
        logic [9:0] v;
        logic [3:0] exp;   // {visible, sync_start, sync_end, total}
    } v_vec_t;

    v_vec_t v_tab[12];

    int exp_h;
    int le_count;
    int vis_count;
    logic [3:0] v_exp;

    initial begin
        v_tab[0]  = '{10'd0,    4'b0000};
        v_tab[1]  = '{10'd599,  4'b0000};
        v_tab[2]  = '{10'd600,  4'b1000};
        v_tab[3]  = '{10'd601,  4'b0100};
        v_tab[4]  = '{10'd602,  4'b0000};
        v_tab[5]  = '{10'd604,  4'b0000};
        v_tab[6]  = '{10'd605,  4'b0010};
        v_tab[7]  = '{10'd606,  4'b0000};
        v_tab[8]  = '{10'd627,  4'b0000};
        v_tab[9]  = '{10'd628,  4'b0001};
        v_tab[10] = '{10'd629,  4'b0000};
        v_tab[11] = '{10'd1023, 4'b0000};

        // ---- reset is asynchronous: outputs clear before any clock edge ----
        rst    = 1'b0;
        vcount = 10'd0;
        #10;
        check("reset_hcount_async", 32'(hcount), 32'd0);
        check("reset_line_end_async", 32'(line_end), 32'd0);
        repeat (2) @(negedge clk);
        check("reset_hcount_clocked", 32'(hcount), 32'd0);
        check("reset_line_end_clocked", 32'(line_end), 32'd0);
        check("reset_h_strobes", 32'(h_actual()), 32'(h_model(0)));

        // ---- release away from the rising edge, then 5 clocks ----
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("release_5_clocks", 32'(hcount), 32'd5);
        exp_h = 5;

        // ---- three full lines against a counter model ----
        le_count  = 0;
        vis_count = 0;
        for (int c = 0; c < 3 * 1056; c++) begin
            @(negedge clk);
            exp_h = (exp_h == 1055) ? 0 : exp_h + 1;
            check("line_hcount", 32'(hcount), 32'(exp_h));
            check("line_h_strobes", 32'(h_actual()), 32'(h_model(exp_h)));
            check("unrep_h_visible", 32'(h_vis_b), 32'd0);
            if (line_end) le_count++;
            if (h_match_visible) vis_count++;
        end
        check("line_end_pulses_3_lines", 32'(le_count), 32'd3);
        check("h_visible_pulses_3_lines", 32'(vis_count), 32'd3);

        // ---- vertical strobes: table then exhaustive sweep ----
        for (int i = 0; i < 12; i++) begin
            vcount = v_tab[i].v;
            #1;
            check("v_table", 32'({v_match_visible, v_match_sync_start, v_match_sync_end, v_match_total}),
                  32'(v_tab[i].exp));
        end
        for (int v = 0; v < 1024; v++) begin
            vcount = 10'(v);
            #1;
            v_exp = {v == 600, v == 601, v == 605, v == 628};
            check("v_sweep", 32'({v_match_visible, v_match_sync_start, v_match_sync_end, v_match_total}),
                  32'(v_exp));
        end
        vcount = 10'd0;

        // ---- mid-line asynchronous reset at hcount = 500 ----
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        repeat (500) @(negedge clk);
        check("midline_reach_500", 32'(hcount), 32'd500);
        #3;
        rst = 1'b0;
        #1;
        check("midline_async_hcount", 32'(hcount), 32'd0);
        check("midline_async_line_end", 32'(line_end), 32'd0);
        check("midline_h_strobes", 32'(h_actual()), 32'(h_model(0)));
        vcount = 10'd600;
        #1;
        check("v_match_during_reset", 32'(v_match_visible), 32'd1);
        vcount = 10'd0;
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midline_resume_1", 32'(hcount), 32'd1);
        check("midline_resume_line_end", 32'(line_end), 32'd0);
        @(negedge clk);
        check("midline_resume_2", 32'(hcount), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_h_timing_core.md
Name: vga_h_timing_core

Overview:
- Horizontal timing core for the 800x600@60 Hz VGA pipeline, clocked by the 40 MHz pixel clock.
- Holds the free-running 11-bit horizontal pixel counter and emits a once-per-line pulse that advances the vertical counter.
- Provides equality-match strobes on the horizontal count (11-bit) and on an externally supplied vertical count (10-bit).
- Downstream SR flops turn these strobes into the drawing, hsync and vsync windows.

Parameters:
- H_TOTAL, 1056, pixel clocks per line; count range 0..H_TOTAL-1.
- H_VISIBLE, 800, first non-visible pixel.
- H_SYNC_START, 840, first hsync pixel.
- H_SYNC_END, 968, first pixel after hsync.
- V_VISIBLE, 600, first non-visible line.
- V_SYNC_START, 601, first vsync line.
- V_SYNC_END, 605, first line after vsync.
- V_TOTAL, 628, lines per frame (match index for last-line logic).

Ports:
- clk  in  1  pixel clock, rising-edge active.
- rst  in  1  asynchronous, active-low reset.
- vcount  in  10  current line number from the vertical counter.
- hcount  out  11  current pixel index.
- line_end  out  1  registered one-cycle pulse marking the last pixel of each line.
- h_match_last  out  1  hcount == H_TOTAL-1.
- h_match_visible  out  1  hcount == H_VISIBLE.
- h_match_sync_start  out  1  hcount == H_SYNC_START.
- h_match_sync_end  out  1  hcount == H_SYNC_END.
- v_match_visible  out  1  vcount == V_VISIBLE.
- v_match_sync_start  out  1  vcount == V_SYNC_START.
- v_match_sync_end  out  1  vcount == V_SYNC_END.
- v_match_total  out  1  vcount == V_TOTAL.

Behaviour:
- Reset (rst=0, asynchronous): hcount=0 and line_end=0 immediately, independent of clk.
  - Comparator outputs follow their inputs combinationally, even during reset.
- Deassertion of rst takes effect at the next rising clk. The first clocked edge after release moves hcount from 0 to 1.
- Counter, each rising clk: if hcount == H_TOTAL-1, hcount <= 0; else hcount <= hcount+1.
  - 11-bit unsigned; never exceeds H_TOTAL-1.
  - Period is exactly H_TOTAL clocks: 1056 clocks = 26.4 us at 40 MHz.
- line_end is a flop output, not a combinational decode, so it is glitch-free when used as the vertical counter's clock.
  - It loads 1 when the next hcount equals H_TOTAL-1, otherwise 0.
  - It is therefore high for exactly one clock, aligned with hcount == H_TOTAL-1.
  - It falls on the edge where hcount wraps to 0, giving exactly one rising edge per line.
- Matches are purely combinational equality, zero latency. Each is high exactly while its count equals the constant.
  - Each horizontal match fires once per line, one clock wide.
  - Vertical matches stay high for the whole line while vcount is equal.
- A constant that is not representable in the comparator width (≥ 2^width) never matches.
  - This is legal; no truncation of the constant is allowed.
- Mid-line reset: the counter returns to 0 at once and line_end drops. Matches on hcount re-evaluate immediately.
- No enable input; the counter runs on every clock edge while out of reset.

Decomposition:
- Shared package vga_timing_pkg holds the SVGA constants (1056/800/840/968 and 628/600/601/605) and the counter widths HW=11 and VW=10.
- One natural sub-module: eq_comparator.
  - Parameter WIDTH; inputs input_value[WIDTH-1:0] and loaded_value[WIDTH-1:0]; output match.
  - Instantiated four times with WIDTH=11 and four times with WIDTH=10.

Test Plan:
- Reset: hold rst=0 for 10 ns, toggle clk → hcount=0, line_end=0. Release, 5 clocks → hcount=5.
- Wrap: run 1056 clocks from reset → hcount goes 1055 then 0. line_end=1 only during hcount=1055. Exactly one line_end pulse per 1056 clocks over 3 lines.
- Horizontal matches: over one line, h_match_visible high only at hcount=800.
  - h_match_sync_start high only at 840; h_match_sync_end high only at 968; h_match_last high only at 1055.
  - Each is one clock wide.
- Vertical matches: drive vcount 0..1023 → v_match_visible only at 600, v_match_sync_start only at 601, v_match_sync_end only at 605, v_match_total only at 628.
- Async reset mid-line: at hcount=500, pulse rst low between clock edges → hcount=0 before the next edge. Counting resumes at 1 after release; line_end stays 0.
- Unrepresentable constant: set H_VISIBLE=2048 → h_match_visible stays 0 over 2 full lines.
